core_run_ctrl: RTL and testbench

Simulation and FPGA bring-up run controller for the RV32IM pipeline. It generalises the fixed "hold reset, run N ns, stop" harness into a parametrised sequential block:
- programmable reset hold and watchdog cycle budget;
- N-hart retire and store monitoring;
- riscv-tests style `tohost` halt detection, with pass/fail, exit code and performance counters.

It sits between the top-level clock/reset source and one or more `rv32i_core` instances, and drives their active-high synchronous `rst`.

---
 rtl/core_run_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_core_run_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//   Run controller for simulation / FPGA bring-up of one or more RV32IM cores.
//   It holds the cores in reset for a programmable time, lets them run under a
//   watchdog, and watches every hart's store port for a riscv-tests style
//   `tohost` write that ends the run. At the end of a run it reports
//   pass/fail, exit code, the halting hart and performance counters.
//
//   Optional build macro:
//     RUN_CTRL_ECALL_HALT_EN  - a retired ECALL (32'h0000_0073) on any hart
//                               also ends the run, with exit code 0 / pass.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-low block reset
//   start          in   begin a run (pulse or level), honoured in IDLE/DONE
//   core_rst       out  active-high synchronous reset to all cores (registered)
//   retire_valid   in   [NUM_HARTS]     per-hart retire strobe
//   retire_instr   in   [32*NUM_HARTS]  retired instruction words
//   mem_wr_en      in   [NUM_HARTS]     per-hart data store strobe
//   mem_wr_addr    in   [32*NUM_HARTS]  store addresses
//   mem_wr_data    in   [32*NUM_HARTS]  store data
//   done           out  run finished (sticky until next start)
//   pass           out  exit code 0 and no watchdog expiry
//   timeout        out  watchdog expired
//   exit_code      out  [31]  tohost data[31:1] of the halting store
//   halt_hart      out  [3]   index of the halting hart
//   cycle_count    out  [CNT_W] RUN cycles elapsed (saturating)
//   retire_count   out  [CNT_W] retired instructions, all harts (saturating)
// -----------------------------------------------------------------------------

// Per-hart halt detection: a qualifying tohost store and an ECALL retire.
module core_run_ctrl_hart #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        retire_i,
  input  logic [31:0] instr_i,
  output logic        tohost_hit_o,
  output logic        ecall_hit_o
);
  // Only odd data marks "finished"; even tohost writes are console traffic etc.
  assign tohost_hit_o = wr_en_i && (wr_addr_i == TOHOST_ADDR) && wr_data_i[0];
  assign ecall_hit_o  = retire_i && (instr_i == 32'h0000_0073);
endmodule

module core_run_ctrl #(
  parameter int          NUM_HARTS       = 1,
  parameter int          RST_HOLD_CYCLES = 2,
  parameter int          MAX_CYCLES      = 120,
  parameter int          CNT_W           = 32,
  parameter logic [31:0] TOHOST_ADDR     = 32'h0000_1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    core_rst,
  input  logic [NUM_HARTS-1:0]    retire_valid,
  input  logic [32*NUM_HARTS-1:0] retire_instr,
  input  logic [NUM_HARTS-1:0]    mem_wr_en,
  input  logic [32*NUM_HARTS-1:0] mem_wr_addr,
  input  logic [32*NUM_HARTS-1:0] mem_wr_data,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [30:0]             exit_code,
  output logic [2:0]              halt_hart,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        retire_count
);

  localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  // Dedicated watchdog counter so the timeout does not depend on CNT_W
  // (cycle_count may saturate before MAX_CYCLES in narrow builds).
  localparam int WW = $clog2(MAX_CYCLES);
  localparam int PW = $clog2(NUM_HARTS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic        hit;
    logic [30:0] code;
    logic [2:0]  hart;
  } halt_t;

  // ---------------------------------------------------------------------------
  // Per-hart views and detection
  // ---------------------------------------------------------------------------
  logic [NUM_HARTS-1:0][31:0] wr_addr_v, wr_data_v, instr_v;
  logic [NUM_HARTS-1:0]       tohost_hit, ecall_hit;

  assign wr_addr_v = mem_wr_addr;
  assign wr_data_v = mem_wr_data;
  assign instr_v   = retire_instr;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    core_run_ctrl_hart #(.TOHOST_ADDR(TOHOST_ADDR)) u_hart (
      .wr_en_i      (mem_wr_en[h]),
      .wr_addr_i    (wr_addr_v[h]),
      .wr_data_i    (wr_data_v[h]),
      .retire_i     (retire_valid[h]),
      .instr_i      (instr_v[h]),
      .tohost_hit_o (tohost_hit[h]),
      .ecall_hit_o  (ecall_hit[h])
    );
  end

  // Halt arbitration. Loops run high-to-low so the lowest index is written
  // last and wins; the tohost loop runs after the ECALL loop so a store
  // beats an ECALL in the same cycle.
  halt_t halt;
  always_comb begin
    halt = '0;
`ifdef RUN_CTRL_ECALL_HALT_EN
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (ecall_hit[h]) begin
        halt.hit  = 1'b1;
        halt.code = '0;
        halt.hart = 3'(h);
      end
    end
`endif
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (tohost_hit[h]) begin
        halt.hit  = 1'b1;
        halt.code = wr_data_v[h][31:1];
        halt.hart = 3'(h);
      end
    end
  end

`ifndef RUN_CTRL_ECALL_HALT_EN
  // ECALL detection is built but has no consumer in this configuration.
  logic unused_ecall;
  assign unused_ecall = ^ecall_hit;
`endif

  // Retire popcount and saturating accumulate (one spare bit catches overflow).
  logic [PW-1:0]    pop;
  logic [CNT_W:0]   ret_sum;
  always_comb begin
    pop = '0;
    for (int h = 0; h < NUM_HARTS; h++) pop = pop + PW'(retire_valid[h]);
  end

  // ---------------------------------------------------------------------------
  // Reset deassertion synchroniser: the FSM may only leave IDLE once the
  // released reset has crossed two flops.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       run_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run_en = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // FSM and result registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
  logic             done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic [30:0]      code_q, code_d;
  logic [2:0]       hart_q, hart_d;
  logic             core_rst_q, core_rst_d;
  logic             go;

  assign ret_sum = {1'b0, ret_q} + (CNT_W + 1)'(pop);
  assign go      = start && ((state_q == S_IDLE && run_en) || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wd_d    = wd_q;
    cyc_d   = cyc_q;
    ret_d   = ret_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    code_d  = code_q;
    hart_d  = hart_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_RESET;
          hold_d  = HW'(RST_HOLD_CYCLES - 1);
          wd_d    = '0;
          cyc_d   = '0;
          ret_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          code_d  = '0;
          hart_d  = '0;
        end
      end

      // hold_q counts down the remaining RESET cycles after this one.
      S_RESET: begin
        if (hold_q == '0) state_d = S_RUN;
        else              hold_d  = hold_q - 1'b1;
      end

      S_RUN: begin
        wd_d = wd_q + 1'b1;
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        ret_d = ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
        if (halt.hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (halt.code == '0);
          tmo_d   = 1'b0;
          code_d  = halt.code;
          hart_d  = halt.hart;
        end else if (wd_q == WW'(MAX_CYCLES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Cores run only in RUN; DONE re-asserts reset to freeze them.
  assign core_rst_d = (state_d != S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      wd_q       <= '0;
      cyc_q      <= '0;
      ret_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      code_q     <= '0;
      hart_q     <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wd_q       <= wd_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      code_q     <= code_d;
      hart_q     <= hart_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = tmo_q;
  assign exit_code    = code_q;
  assign halt_hart    = hart_q;
  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two harts, 2-cycle reset hold, 120-cycle watchdog.
// A second instance with 4-bit counters exercises counter saturation.
module tb_core_run_ctrl;
  localparam int          NH = 2;
  localparam logic [31:0] TH = 32'h0000_1000;
  localparam int          MAXC = 120;

  logic clk = 1'b0;
  logic rst, start;
  logic [NH-1:0]    rv, we;
  logic [32*NH-1:0] ri, wa, wd;

  logic        core_rst, done, pass, timeout;
  logic [30:0] exit_code;
  logic [2:0]  halt_hart;
  logic [31:0] cycle_count, retire_count;

  logic        s_core_rst, s_done, s_pass, s_timeout;
  logic [30:0] s_code;
  logic [2:0]  s_hh;
  logic [3:0]  s_cyc, s_ret;

  always #5 clk = ~clk;

  core_run_ctrl #(.NUM_HARTS(NH), .RST_HOLD_CYCLES(2), .MAX_CYCLES(MAXC),
                  .CNT_W(32), .TOHOST_ADDR(TH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .core_rst(core_rst),
    .retire_valid(rv), .retire_instr(ri),
    .mem_wr_en(we), .mem_wr_addr(wa), .mem_wr_data(wd),
    .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code),
    .halt_hart(halt_hart), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  core_run_ctrl #(.NUM_HARTS(NH), .RST_HOLD_CYCLES(2), .MAX_CYCLES(MAXC),
                  .CNT_W(4), .TOHOST_ADDR(TH)) u_sat (
    .clk(clk), .rst(rst), .start(start), .core_rst(s_core_rst),
    .retire_valid(2'b11), .retire_instr(64'h0),
    .mem_wr_en(2'b00), .mem_wr_addr(64'h0), .mem_wr_data(64'h0),
    .done(s_done), .pass(s_pass), .timeout(s_timeout), .exit_code(s_code),
    .halt_hart(s_hh), .cycle_count(s_cyc), .retire_count(s_ret)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          dly;     // RUN cycle index in which the stores are presented
    logic [1:0]  we;
    logic [31:0] a0, d0, a1, d1;
    logic        pas, to;
    logic [30:0] code;
    logic [2:0]  hh;
    int          cyc;     // expected cycle_count when done rises
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rv = '0; ri = '0; we = '0; wa = '0; wd = '0;
  endtask

  // Start from IDLE/DONE, check the clear, wait (bounded) for RUN entry.
  task automatic begin_run(output bit ok);
    int waited;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_cyc", cycle_count, 0);
    chk("clear_code", exit_code, 0);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      if (!core_rst) begin ok = 1'b1; break; end
      tick();
      waited++;
    end
    chk("run_entry", ok, 1);
    chk("hold_len", waited, 2);
  endtask

  bit          ok, fin, m_halt;
  int          c, m_cyc, m_ret;
  logic [30:0] m_code;
  logic [2:0]  m_hh;
  logic [31:0] a, d, ins;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    tv[0] = '{40,  2'b01, TH, 32'h1,  32'h0, 32'h0, 1'b1, 1'b0, 31'd0, 3'd0, 41};
    tv[1] = '{10,  2'b11, TH, 32'h7,  TH,    32'h1, 1'b0, 1'b0, 31'd3, 3'd0, 11};
    tv[2] = '{3,   2'b11, TH, 32'h6,  TH,    32'h5, 1'b0, 1'b0, 31'd2, 3'd1, 4};
    tv[3] = '{20,  2'b11, TH + 32'd4, 32'h1, TH, 32'h1, 1'b1, 1'b0, 31'd0, 3'd1, 21};
    tv[4] = '{119, 2'b01, TH, 32'h1,  32'h0, 32'h0, 1'b1, 1'b0, 31'd0, 3'd0, 120};
    tv[5] = '{0,   2'b01, TH, 32'h2,  32'h0, 32'h0, 1'b0, 1'b1, 31'd0, 3'd0, 120};
    tv[6] = '{5,   2'b10, 32'h0, 32'h0, TH, 32'hFFFF_FFFF, 1'b0, 1'b0, 31'h7FFF_FFFF, 3'd1, 6};

    // ---- reset values and reset/start timing (start sampled at edge 5) ----
    rst = 1'b0; start = 1'b0; idle_in();
    tick(); tick();                               // edges 1,2
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_code", exit_code, 0);
    chk("rst_hart", halt_hart, 0);
    chk("rst_cyc", cycle_count, 0);
    chk("rst_ret", retire_count, 0);
    rst = 1'b1;
    tick(); tick();                               // edges 3,4
    start = 1'b1;
    tick();                                       // edge 5
    start = 1'b0;
    chk("hold_e5", core_rst, 1);
    tick();                                       // edge 6
    chk("hold_e6", core_rst, 1);
    tick();                                       // edge 7
    chk("run_e7", core_rst, 0);
    chk("run_results", {done, pass, timeout}, 0);
    // start while running is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_rst", core_rst, 0);
    chk("start_in_run_cyc", cycle_count, 1);
    we = 2'b01; wa = {32'h0, TH}; wd = {32'h0, 32'h1};
    tick();
    idle_in();
    chk("first_halt_done", done, 1);
    chk("first_halt_cyc", cycle_count, 2);

    // ---- table-driven runs ----
    for (int v = 0; v < 7; v++) begin
      begin_run(ok);
      c = 0; fin = 1'b0;
      while (c < 200 && !fin) begin
        idle_in();
        if (c == tv[v].dly) begin
          we = tv[v].we; wa = {tv[v].a1, tv[v].a0}; wd = {tv[v].d1, tv[v].d0};
        end
        tick();
        if (done) fin = 1'b1;
        else c++;
      end
      idle_in();
      chk("tv_done", fin, 1);
      chk("tv_done_time", c + 1, tv[v].cyc);
      chk("tv_pass", pass, tv[v].pas);
      chk("tv_timeout", timeout, tv[v].to);
      chk("tv_code", exit_code, tv[v].code);
      chk("tv_hart", halt_hart, tv[v].hh);
      chk("tv_cyc", cycle_count, tv[v].cyc);
      chk("tv_core_rst", core_rst, 1);
      if (v == 0) begin
        chk("sat_ret", s_ret, 15);
        chk("sat_cyc", s_cyc, 15);
        tick();
        chk("sat_ret_hold", s_ret, 15);
        chk("done_hold", {done, pass, cycle_count}, {1'b1, 1'b1, 32'd41});
      end
    end

    // ---- randomized runs vs. transaction-level model ----
    for (int r = 0; r < 10; r++) begin
      begin_run(ok);
      m_cyc = 0; m_ret = 0; fin = 1'b0;
      while (!fin) begin
        for (int h = 0; h < NH; h++) begin
          rv[h] = ($urandom_range(0, 1) == 1);
          we[h] = ($urandom_range(0, 3) == 0);
          a = ($urandom_range(0, 1) == 1) ? TH : $urandom;
          d = $urandom;
          if ($urandom_range(0, 15) != 0) d[0] = 1'b0;
          ins = ($urandom_range(0, 31) == 0) ? 32'h0000_0073 : $urandom;
          wa[32*h +: 32] = a;
          wd[32*h +: 32] = d;
          ri[32*h +: 32] = ins;
        end
        m_halt = 1'b0; m_code = '0; m_hh = '0;
        for (int h = 0; h < NH; h++)
          if (!m_halt && we[h] && wa[32*h +: 32] == TH && wd[32*h]) begin
            m_halt = 1'b1; m_code = wd[32*h+1 +: 31]; m_hh = 3'(h);
          end
`ifdef RUN_CTRL_ECALL_HALT_EN
        for (int h = 0; h < NH; h++)
          if (!m_halt && rv[h] && ri[32*h +: 32] == 32'h0000_0073) begin
            m_halt = 1'b1; m_code = '0; m_hh = 3'(h);
          end
`endif
        for (int h = 0; h < NH; h++) m_ret += int'(rv[h]);
        m_cyc++;
        tick();
        if (m_halt || m_cyc == MAXC) begin
          fin = 1'b1;
          chk("rnd_done", done, 1);
          chk("rnd_pass", pass, m_halt && (m_code == 0));
          chk("rnd_timeout", timeout, !m_halt);
          chk("rnd_code", exit_code, m_code);
          chk("rnd_hart", halt_hart, m_hh);
          chk("rnd_cyc", cycle_count, m_cyc);
          chk("rnd_ret", retire_count, m_ret);
        end else begin
          chk("rnd_busy", done, 0);
        end
      end
      idle_in();
    end

    // ---- ECALL retire on hart 1 ----
    begin_run(ok);
    for (int i = 0; i < 5; i++) tick();
    rv = 2'b10; ri = {32'h0000_0073, 32'h0};
    tick();
    idle_in();
`ifdef RUN_CTRL_ECALL_HALT_EN
    chk("ecall_done", done, 1);
    chk("ecall_pass", pass, 1);
    chk("ecall_hart", halt_hart, 1);
    chk("ecall_cyc", cycle_count, 6);
`else
    chk("ecall_no_halt", done, 0);
    chk("ecall_counted", retire_count, 1);
    we = 2'b01; wa = {32'h0, TH}; wd = {32'h0, 32'h1};
    tick();
    idle_in();
    chk("ecall_end_done", done, 1);
    chk("ecall_end_cyc", cycle_count, 7);
`endif

    // ---- async reset mid-run, then synchronised release ----
    begin_run(ok);
    tick(); tick(); tick();
    #3 rst = 1'b0;
    #1;
    chk("async_core_rst", core_rst, 1);
    chk("async_cyc", cycle_count, 0);
    chk("async_done", done, 0);
    tick();
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("sync_release_hold", core_rst, 1);
    tick();
    start = 1'b0;
    chk("sync_release_run", core_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
